// File: rtl/picosoc_irq_pkg.sv
`default_nettype none
//==============================================================================
// Package  : picosoc_irq_pkg
// Brief    : Register map and window decode shared by the external IRQ block.
// Revision : 1.0 - initial release
//==============================================================================
package picosoc_irq_pkg;

    localparam int IRQ_WIN_BYTES = 32;
    localparam int IRQ_OFF_W     = $clog2(IRQ_WIN_BYTES);

    localparam logic [IRQ_OFF_W-1:0] REG_PENDING = 5'h00;
    localparam logic [IRQ_OFF_W-1:0] REG_ENABLE  = 5'h04;
    localparam logic [IRQ_OFF_W-1:0] REG_EDGE    = 5'h08;
    localparam logic [IRQ_OFF_W-1:0] REG_RAW     = 5'h0C;
    localparam logic [IRQ_OFF_W-1:0] REG_SOFTSET = 5'h10;

    // Window is naturally aligned, so only the bits above the offset are compared.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:IRQ_OFF_W] == base[31:IRQ_OFF_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_line_sampler.sv
`default_nettype none
//==============================================================================
// Module   : irq_line_sampler
// Brief    : Input sampling stage plus rising-edge detect for the IRQ lines.
//            IRQ_SYNC_EN selects a 2-flop synchronizer instead of one register.
// Revision : 1.0 - initial release
//==============================================================================
module irq_line_sampler
    import picosoc_irq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_prev;

`ifdef IRQ_SYNC_EN
    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_raw  <= '0;
        end else begin
            r_meta <= in;
            r_raw  <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw <= '0;
        end else begin
            r_raw <= in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_raw;
        end
    end

    assign raw  = r_raw;
    assign rise = r_raw & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/axi_ext_irq_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : axi_ext_irq_ctrl
// Brief    : External interrupt controller with AXI4-lite register window,
//            feeding the picorv32_axi irq vector. Optional macro: IRQ_SYNC_EN.
// Revision : 1.0 - initial release
//==============================================================================
module axi_ext_irq_ctrl
    import picosoc_irq_pkg::*;
#(
    parameter int          NUM_IRQ   = 8,
    parameter int          IRQ_BASE  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_axi_awvalid,
    output logic               mem_axi_awready,
    input  logic [31:0]        mem_axi_awaddr,
    input  logic [2:0]         mem_axi_awprot,
    input  logic               mem_axi_wvalid,
    output logic               mem_axi_wready,
    input  logic [31:0]        mem_axi_wdata,
    input  logic [3:0]         mem_axi_wstrb,
    output logic               mem_axi_bvalid,
    input  logic               mem_axi_bready,
    input  logic               mem_axi_arvalid,
    output logic               mem_axi_arready,
    input  logic [31:0]        mem_axi_araddr,
    input  logic [2:0]         mem_axi_arprot,
    output logic               mem_axi_rvalid,
    input  logic               mem_axi_rready,
    output logic [31:0]        mem_axi_rdata,
    input  logic [NUM_IRQ-1:0] ext_irq,
    output logic [31:0]        irq
);

    logic               r_awready, r_aw_latched;
    logic [31:0]        r_awaddr;
    logic               r_wready, r_w_latched;
    logic [NUM_IRQ-1:0] r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_bvalid;
    logic               r_arready, r_ar_latched;
    logic [31:0]        r_araddr;
    logic               r_rvalid;
    logic [31:0]        r_rdata;

    logic [NUM_IRQ-1:0] r_pending, r_enable, r_edge;
    logic [31:0]        r_irq;

    logic [NUM_IRQ-1:0] w_raw, w_rise, w_event, w_w1c, w_softset;
    logic               w_commit, w_wr_en;
    logic [IRQ_OFF_W-1:0] w_wr_off;
    logic [31:0]        w_rdata;
    logic               w_unused_ok;

    irq_line_sampler #(
        .WIDTH (NUM_IRQ)
    ) u_sampler (
        .clk   (clk),
        .reset (reset),
        .in    (ext_irq),
        .raw   (w_raw),
        .rise  (w_rise)
    );

    // Register update fires once per write, on the edge where bvalid rises.
    assign w_commit  = r_aw_latched & r_w_latched & ~r_bvalid;
    assign w_wr_en   = w_commit & in_window(r_awaddr, BASE_ADDR) & (r_wstrb == 4'hF);
    assign w_wr_off  = r_awaddr[IRQ_OFF_W-1:0];
    assign w_w1c     = (w_wr_en && w_wr_off == REG_PENDING) ? r_wdata : '0;
    assign w_softset = (w_wr_en && w_wr_off == REG_SOFTSET) ? r_wdata : '0;
    assign w_event   = (r_edge & w_rise) | (~r_edge & w_raw);

    always_comb begin
        w_rdata = '0;
        if (in_window(r_araddr, BASE_ADDR)) begin
            case (r_araddr[IRQ_OFF_W-1:0])
                REG_PENDING: w_rdata = 32'(r_pending);
                REG_ENABLE:  w_rdata = 32'(r_enable);
                REG_EDGE:    w_rdata = 32'(r_edge);
                REG_RAW:     w_rdata = 32'(w_raw);
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_awready    <= 1'b0;
            r_aw_latched <= 1'b0;
            r_awaddr     <= '0;
            r_wready     <= 1'b0;
            r_w_latched  <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bvalid     <= 1'b0;
            r_arready    <= 1'b0;
            r_ar_latched <= 1'b0;
            r_araddr     <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (r_awready) begin
                r_awready <= 1'b0;
                if (mem_axi_awvalid) begin
                    r_aw_latched <= 1'b1;
                    r_awaddr     <= mem_axi_awaddr;
                end
            end else if (mem_axi_awvalid && !r_aw_latched) begin
                r_awready <= 1'b1;
            end

            if (r_wready) begin
                r_wready <= 1'b0;
                if (mem_axi_wvalid) begin
                    r_w_latched <= 1'b1;
                    r_wdata     <= mem_axi_wdata[NUM_IRQ-1:0];
                    r_wstrb     <= mem_axi_wstrb;
                end
            end else if (mem_axi_wvalid && !r_w_latched) begin
                r_wready <= 1'b1;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && mem_axi_bready) begin
                r_bvalid     <= 1'b0;
                r_aw_latched <= 1'b0;
                r_w_latched  <= 1'b0;
            end

            // rvalid blocks new reads, so the address latch can free up at load time.
            if (r_arready) begin
                r_arready <= 1'b0;
                if (mem_axi_arvalid) begin
                    r_ar_latched <= 1'b1;
                    r_araddr     <= mem_axi_araddr;
                end
            end else if (mem_axi_arvalid && !r_ar_latched && !r_rvalid) begin
                r_arready <= 1'b1;
            end

            if (r_ar_latched && !r_rvalid) begin
                r_rdata      <= w_rdata;
                r_rvalid     <= 1'b1;
                r_ar_latched <= 1'b0;
            end else if (r_rvalid && mem_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Set terms are OR-ed after the clear mask so a coincident event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_irq     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_w1c) | w_event | w_softset;
            if (w_wr_en && w_wr_off == REG_ENABLE) begin
                r_enable <= r_wdata;
            end
            if (w_wr_en && w_wr_off == REG_EDGE) begin
                r_edge <= r_wdata;
            end
            r_irq <= 32'(r_pending & r_enable) << IRQ_BASE;
        end
    end

    assign w_unused_ok = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_wdata};

    assign mem_axi_awready = r_awready;
    assign mem_axi_wready  = r_wready;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_arready = r_arready;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign irq             = r_irq;

endmodule
`default_nettype wire
